// File: rtl/img_pkg.sv
// Shared image-pipeline constants: coordinate widths and pixel polarity.
package img_pkg;
   localparam int H_W_DEF        = 11;
   localparam int V_W_DEF        = 11;
   localparam int CNT_W_DEF      = 20;
   localparam int MIN_PIXELS_DEF = 16;
   localparam logic BLACK        = 1'b0;
endpackage

// File: rtl/sync_edge_det.sv
// N-bit edge detector: one register of history, rise/fall valid in the cycle the input changes.
module sync_edge_det #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] d,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall
);
   logic [N-1:0] d_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= '0;
      else        d_q <= d;
   end

   assign rise = d & ~d_q;
   assign fall = ~d & d_q;
endmodule

// File: rtl/binary_bbox.sv
// Bounding box and pixel count of black pixels in a binarized frame, reported once per vsync.
module binary_bbox
   import img_pkg::*;
#(
   parameter int H_W        = H_W_DEF,
   parameter int V_W        = V_W_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int MIN_PIXELS = MIN_PIXELS_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_vsync,
   input  logic             frame_hsync,
   input  logic             frame_de,
   input  logic             monoc,
   output logic [H_W-1:0]   box_left,
   output logic [H_W-1:0]   box_right,
   output logic [V_W-1:0]   box_top,
   output logic [V_W-1:0]   box_bottom,
   output logic [CNT_W-1:0] box_pixels,
   output logic             box_found,
   output logic             box_valid
);
   logic [1:0]       edge_rise;
   logic [1:0]       edge_fall;
   logic             vs_rise;
   logic             de_fall;
   logic             target;
   logic             armed;
   logic [H_W-1:0]   x_cnt;
   logic [V_W-1:0]   y_cnt;
   logic [H_W-1:0]   min_x, max_x, nx_min_x, nx_max_x;
   logic [V_W-1:0]   min_y, max_y, nx_min_y, nx_max_y;
   logic [CNT_W-1:0] cnt, nx_cnt;
   logic             nx_found;
   logic             unused_ok;

   sync_edge_det #(.N(2)) u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({frame_vsync, frame_de}),
      .rise  (edge_rise),
      .fall  (edge_fall)
   );

   assign vs_rise   = edge_rise[1];
   assign de_fall   = edge_fall[0];
   assign target    = frame_de && (monoc == BLACK);
   assign unused_ok = ^{frame_hsync, edge_fall[1], edge_rise[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
      end else if (frame_de) begin
         if (x_cnt != '1) x_cnt <= x_cnt + 1'b1;
      end else if (de_fall) begin
         x_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_cnt <= '0;
      end else if (vs_rise) begin
         y_cnt <= '0;
      end else if (de_fall && (y_cnt != '1)) begin
         y_cnt <= y_cnt + 1'b1;
      end
   end

   // Accumulators merged with the current pixel; this lets a pixel on the vsync-rise cycle
   // still land in the frame being closed.
   always_comb begin
      nx_min_x = min_x;
      nx_max_x = max_x;
      nx_min_y = min_y;
      nx_max_y = max_y;
      nx_cnt   = cnt;
      if (target) begin
         if (x_cnt < min_x) nx_min_x = x_cnt;
         if (x_cnt > max_x) nx_max_x = x_cnt;
         if (y_cnt < min_y) nx_min_y = y_cnt;
         if (y_cnt > max_y) nx_max_y = y_cnt;
         if (cnt != '1)     nx_cnt   = cnt + 1'b1;
      end
   end

   assign nx_found = (nx_cnt >= CNT_W'(MIN_PIXELS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_x <= '1;
         max_x <= '0;
         min_y <= '1;
         max_y <= '0;
         cnt   <= '0;
      end else if (vs_rise) begin
         min_x <= '1;
         max_x <= '0;
         min_y <= '1;
         max_y <= '0;
         cnt   <= '0;
      end else begin
         min_x <= nx_min_x;
         max_x <= nx_max_x;
         min_y <= nx_min_y;
         max_y <= nx_max_y;
         cnt   <= nx_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed      <= 1'b0;
         box_valid  <= 1'b0;
         box_found  <= 1'b0;
         box_pixels <= '0;
         box_left   <= '0;
         box_right  <= '0;
         box_top    <= '0;
         box_bottom <= '0;
      end else begin
         box_valid <= 1'b0;
         if (vs_rise) begin
            armed <= 1'b1;
            // The very first frame after reset is partial, so it only arms the block.
            if (armed) begin
               box_valid  <= 1'b1;
               box_found  <= nx_found;
               box_pixels <= nx_cnt;
               box_left   <= nx_found ? nx_min_x : '0;
               box_right  <= nx_found ? nx_max_x : '0;
               box_top    <= nx_found ? nx_min_y : '0;
               box_bottom <= nx_found ? nx_max_y : '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_binary_bbox.sv
// Directed bench for binary_bbox: two instances share the stimulus, MIN_PIXELS=16 and MIN_PIXELS=1.
module tb_binary_bbox;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_vsync = 1'b0;
   logic        frame_hsync = 1'b0;
   logic        frame_de = 1'b0;
   logic        monoc = 1'b1;

   logic [10:0] box_left, box_right, box_top, box_bottom;
   logic [19:0] box_pixels;
   logic        box_found, box_valid;
   logic [10:0] o1_left, o1_right, o1_top, o1_bottom;
   logic [19:0] o1_pixels;
   logic        o1_found, o1_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   binary_bbox #(.H_W(11), .V_W(11), .CNT_W(20), .MIN_PIXELS(16)) dut (
      .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .frame_hsync(frame_hsync),
      .frame_de(frame_de), .monoc(monoc),
      .box_left(box_left), .box_right(box_right), .box_top(box_top), .box_bottom(box_bottom),
      .box_pixels(box_pixels), .box_found(box_found), .box_valid(box_valid)
   );

   binary_bbox #(.H_W(11), .V_W(11), .CNT_W(20), .MIN_PIXELS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .frame_hsync(frame_hsync),
      .frame_de(frame_de), .monoc(monoc),
      .box_left(o1_left), .box_right(o1_right), .box_top(o1_top), .box_bottom(o1_bottom),
      .box_pixels(o1_pixels), .box_found(o1_found), .box_valid(o1_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One active line of len pixels, black on columns lo..hi, then one blanking cycle.
   task automatic line(input int len, input int lo, input int hi);
      for (int c = 0; c < len; c++) begin
         frame_de    = 1'b1;
         frame_hsync = 1'b0;
         monoc       = (c >= lo && c <= hi) ? 1'b0 : 1'b1;
         tick();
      end
      frame_de    = 1'b0;
      frame_hsync = 1'b1;
      monoc       = 1'b1;
      tick();
      frame_hsync = 1'b0;
   endtask

   task automatic white_frame(input int w, input int h);
      for (int r = 0; r < h; r++) line(w, 1, 0);
   endtask

   // Raises vsync for one cycle; on return the bench sits in the cycle after detection.
   task automatic vs_up();
      frame_vsync = 1'b1;
      tick();
   endtask

   task automatic vs_down();
      frame_vsync = 1'b0;
      tick();
   endtask

   task automatic chk_box(input string tag, input int l, input int r, input int t, input int b,
                          input int px, input int fnd);
      chk({tag, "_valid"},  box_valid,  1);
      chk({tag, "_left"},   box_left,   l);
      chk({tag, "_right"},  box_right,  r);
      chk({tag, "_top"},    box_top,    t);
      chk({tag, "_bottom"}, box_bottom, b);
      chk({tag, "_pixels"}, box_pixels, px);
      chk({tag, "_found"},  box_found,  fnd);
   endtask

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_valid", box_valid, 0);
      chk("rst_pixels", box_pixels, 0);
      chk("rst_left", box_left, 0);
      chk("rst_found", box_found, 0);
      rst_n = 1'b1;
      tick();

      // Two all-white 8x4 frames: the first vsync only arms
      white_frame(8, 4);
      vs_up();
      chk("arm_valid", box_valid, 0);
      chk("arm_pixels", box_pixels, 0);
      vs_down();
      white_frame(8, 4);
      vs_up();
      chk_box("white", 0, 0, 0, 0, 0, 0);
      vs_down();
      chk("white_pulse_end", box_valid, 0);

      // Black rectangle cols 100..199, rows 50..79; white tail pixels of each line are
      // trimmed since they cannot affect the box
      for (int r = 0; r < 50; r++) line(1, 1, 0);
      for (int r = 50; r < 80; r++) line(200, 100, 199);
      for (int r = 80; r < 480; r++) line(1, 1, 0);
      vs_up();
      chk_box("rect", 100, 199, 50, 79, 3000, 1);
      vs_down();
      chk("rect_pulse_end", box_valid, 0);
      chk("rect_hold_left", box_left, 100);
      chk("rect_hold_pixels", box_pixels, 3000);

      // Single black pixel at (0,0)
      line(8, 0, 0);
      white_frame(8, 3);
      vs_up();
      chk("one_m1_valid", o1_valid, 1);
      chk("one_m1_left", o1_left, 0);
      chk("one_m1_right", o1_right, 0);
      chk("one_m1_top", o1_top, 0);
      chk("one_m1_bottom", o1_bottom, 0);
      chk("one_m1_pixels", o1_pixels, 1);
      chk("one_m1_found", o1_found, 1);
      chk_box("one_m16", 0, 0, 0, 0, 1, 0);
      vs_down();

      // 15 black pixels, row 2, cols 3..17: below threshold, coords forced to 0
      white_frame(20, 2);
      line(20, 3, 17);
      white_frame(20, 1);
      vs_up();
      chk_box("p15", 0, 0, 0, 0, 15, 0);
      vs_down();

      // 16 black pixels, row 2, cols 3..18
      white_frame(20, 2);
      line(20, 3, 18);
      white_frame(20, 1);
      vs_up();
      chk_box("p16", 3, 18, 2, 2, 16, 1);
      vs_down();

      // Black pixel at (639,479) on the same cycle as the vsync rise
      for (int r = 0; r < 479; r++) line(1, 1, 0);
      for (int c = 0; c < 640; c++) begin
         frame_de    = 1'b1;
         monoc       = (c == 639) ? 1'b0 : 1'b1;
         frame_vsync = (c == 639);
         tick();
      end
      chk("simul_m1_valid", o1_valid, 1);
      chk("simul_m1_left", o1_left, 639);
      chk("simul_m1_right", o1_right, 639);
      chk("simul_m1_top", o1_top, 479);
      chk("simul_m1_bottom", o1_bottom, 479);
      chk("simul_m1_pixels", o1_pixels, 1);
      frame_de = 1'b0;
      monoc    = 1'b1;
      vs_down();

      // Following white frame must report empty; vsync then held high for three cycles
      white_frame(8, 4);
      vs_up();
      chk("clean_m1_valid", o1_valid, 1);
      chk("clean_m1_pixels", o1_pixels, 0);
      chk("clean_m1_found", o1_found, 0);
      chk("clean_m1_right", o1_right, 0);
      tick();
      chk("hold_vs_valid1", o1_valid, 0);
      tick();
      chk("hold_vs_valid2", box_valid, 0);
      vs_down();

      // Valid box, then reset in the middle of the next frame
      white_frame(20, 2);
      line(20, 3, 18);
      white_frame(20, 1);
      vs_up();
      chk_box("pre_rst", 3, 18, 2, 2, 16, 1);
      vs_down();
      line(20, 0, 19);
      frame_de = 1'b1;
      monoc    = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_left", box_left, 0);
      chk("midrst_right", box_right, 0);
      chk("midrst_bottom", box_bottom, 0);
      chk("midrst_pixels", box_pixels, 0);
      chk("midrst_found", box_found, 0);
      frame_de = 1'b0;
      monoc    = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      line(20, 0, 19);
      vs_up();
      chk("rearm_valid", box_valid, 0);
      chk("rearm_pixels", box_pixels, 0);
      vs_down();
      white_frame(20, 2);
      line(20, 3, 18);
      white_frame(20, 1);
      vs_up();
      chk_box("post_rst", 3, 18, 2, 2, 16, 1);
      vs_down();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
